// File: rtl/fifo_pixel_drain.sv
// fifo_pixel_drain: pops {x, depth} words from a first-word-fall-through FIFO,
// maps the iteration depth to an RGB colour and presents one pixel per clock
// on an AXI4-Stream style output with start-of-frame (m_tuser) and end-of-line
// (m_tlast) markers. A raster position counter tracks where each pixel lands
// and flags any word whose x column disagrees with it.
//
// Handshake: a pixel transfers on a rising edge where m_tvalid && m_tready.
// m_tvalid is never withdrawn and m_tdata/m_tlast/m_tuser never change while
// m_tvalid=1 and m_tready=0. Upstream, fifo_read_en pops the FIFO head on the
// edge it is high; it is only raised when the output register is free or is
// being emptied in the same cycle.
module fifo_pixel_drain #(
  parameter int DATA_WIDTH    = 21,
  parameter int X_WIDTH       = 11,
  parameter int DEPTH_WIDTH   = 10,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int MAX_ITER      = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic [23:0]           m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser,
  output logic                  err_x_mismatch,
  output logic                  frame_done
);

  localparam int ROW_W = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
  localparam logic [X_WIDTH-1:0]     COL_LAST     = X_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [ROW_W-1:0]       ROW_LAST     = ROW_W'(SCREEN_HEIGHT - 1);
  localparam logic [DEPTH_WIDTH-1:0] DEPTH_IN_SET = DEPTH_WIDTH'(MAX_ITER);

  // Output register and raster position.
  logic [23:0]        r_tdata;
  logic               r_tvalid;
  logic               r_tlast;
  logic               r_tuser;
  logic               r_frame_end;
  logic               r_err;
  logic [X_WIDTH-1:0] r_col;
  logic [ROW_W-1:0]   r_row;

  // Decoded FIFO head and control terms.
  logic [X_WIDTH-1:0]     w_x;
  logic [DEPTH_WIDTH-1:0] w_depth;
  logic [23:0]            w_colour;
  logic                   w_load;
  logic                   w_accept;
  logic                   w_col_last;
  logic                   w_row_last;

  assign w_x     = fifo_data[DATA_WIDTH-1 -: X_WIDTH];
  assign w_depth = fifo_data[DEPTH_WIDTH-1:0];

  // Points inside the set are black; otherwise a modulo-256 ramp of the depth.
  assign w_colour = (w_depth == DEPTH_IN_SET) ? 24'h000000 :
                    {w_depth[7:0], {w_depth[5:0], 2'b00}, 8'hFF - w_depth[7:0]};

  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  // Pop only when the output register is empty or drains this cycle; reset
  // gates the pop so nothing is lost while the block is held.
  assign w_accept     = r_tvalid & m_tready;
  assign w_load       = reset & ~fifo_empty & (~r_tvalid | m_tready);
  assign fifo_read_en = w_load;

  assign m_tdata        = r_tdata;
  assign m_tvalid       = r_tvalid;
  assign m_tlast        = r_tlast;
  assign m_tuser        = r_tuser;
  assign err_x_mismatch = r_err;
  // Pulses in the very cycle the last pixel of the frame is accepted.
  assign frame_done     = w_accept & r_frame_end;

  // Output register: load a new pixel, or go idle once the current one is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tvalid    <= 1'b0;
      r_tdata     <= 24'h000000;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_frame_end <= 1'b0;
    end else if (w_load) begin
      r_tvalid    <= 1'b1;
      r_tdata     <= w_colour;
      r_tlast     <= w_col_last;
      r_tuser     <= (r_col == '0) && (r_row == '0);
      r_frame_end <= w_col_last && w_row_last;
    end else if (w_accept) begin
      r_tvalid    <= 1'b0;
    end
  end

  // Raster position: advance one column per loaded word, wrapping line and frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_load) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + X_WIDTH'(1);
      end
    end
  end

  // Sticky ordering error: the word's own column disagrees with our position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_load && (w_x != r_col)) begin
      r_err <= 1'b1;
    end
  end

endmodule
